// File: rtl/sync_fifo_pkg.sv
// Shared constants and width helpers for the parametrised synchronous FIFO.
package sync_fifo_pkg;

  localparam int DEF_DW        = 6;
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_AF_THRESH = 6;
  localparam int DEF_AE_THRESH = 1;

  // Pointer width: addresses DEPTH entries, wraps modulo DEPTH.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Count width: must represent 0..DEPTH inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Handshake/data bundle between a FIFO user (master) and the FIFO (slave).
interface sync_fifo_param_if
  import sync_fifo_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int CW = cnt_w(DEPTH);

  logic          wr_en;
  logic [DW-1:0] din;
  logic          rd_en;
  logic          flush;
  logic [DW-1:0] dout;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;

  modport master (
    output wr_en, din, rd_en, flush,
    input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en, flush,
    output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_mem.sv
// DEPTH x DW register file: one synchronous write port, one combinational read port.
module sync_fifo_mem #(
  parameter int DW    = 6,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  // Storage write; contents survive reset and flush by design.
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO: pointers, occupancy count, threshold flags,
// sticky overflow/underflow, synchronous flush and FWFT / registered read output.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DW        = DEF_DW,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEF_AF_THRESH,
  parameter int AE_THRESH = DEF_AE_THRESH,
  parameter int FWFT      = 0
) (
  input logic               clk,
  input logic               rst_n,
  sync_fifo_param_if.slave  bus
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  if ((DEPTH < 2) || (DEPTH > 64) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two in 2..64");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
    $error("sync_fifo_param: AF_THRESH must be in 1..DEPTH");
  end
  if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
    $error("sync_fifo_param: AE_THRESH must be in 0..DEPTH-1");
  end

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          r_udf;

  logic          w_full;
  logic          w_empty;
  logic          w_rd_acc;
  logic          w_wr_acc;
  logic [CW-1:0] w_cnt_nxt;
  logic [DW-1:0] w_rdata;

  // Flags come only from the registered count, so they never glitch on inputs.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // Flush blocks both ports; a write into a full FIFO rides on a same-cycle pop.
  assign w_rd_acc = bus.rd_en && !w_empty && !bus.flush;
  assign w_wr_acc = bus.wr_en && (!w_full || w_rd_acc) && !bus.flush;

  // Next occupancy: simultaneous push and pop cancel out.
  always_comb begin
    w_cnt_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_cnt_nxt = r_count + CW'(1);
      2'b01:   w_cnt_nxt = r_count - CW'(1);
      default: w_cnt_nxt = r_count;
    endcase
  end

  // Pointer, count and sticky error state; flush outranks any request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_cnt_nxt;
      if (bus.wr_en && w_full && !w_rd_acc) r_ovf <= 1'b1;
      if (bus.rd_en && w_empty)             r_udf <= 1'b1;
    end
  end

  sync_fifo_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (w_wr_acc),
    .waddr (r_wr_ptr),
    .wdata (bus.din),
    .raddr (r_rd_ptr),
    .rdata (w_rdata)
  );

  if (FWFT != 0) begin : g_fwft
    // Head of queue is shown directly; an empty FIFO presents zero.
    assign bus.dout = w_empty ? '0 : w_rdata;
  end else begin : g_reg
    logic [DW-1:0] r_dout;
    // Registered read data: loads on an accepted pop, otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         r_dout <= '0;
      else if (bus.flush) r_dout <= '0;
      else if (w_rd_acc)  r_dout <= w_rdata;
    end
    assign bus.dout = r_dout;
  end

  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= CW'(AF_THRESH));
  assign bus.almost_empty = (r_count <= CW'(AE_THRESH));
  assign bus.count        = r_count;
  assign bus.overflow     = r_ovf;
  assign bus.underflow    = r_udf;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: registered-read instance and FWFT instance.
module tb_sync_fifo_param;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  sync_fifo_param_if #(.DW(6), .DEPTH(8)) if0 ();
  sync_fifo_param_if #(.DW(6), .DEPTH(8)) if1 ();

  sync_fifo_param #(
    .DW(6), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1), .FWFT(0)
  ) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0.slave)
  );

  sync_fifo_param #(
    .DW(6), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1), .FWFT(1)
  ) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // One clock; returns 1 time unit after the rising edge so outputs are settled.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    if0.wr_en = 1'b0; if0.rd_en = 1'b0; if0.flush = 1'b0; if0.din = '0;
    if1.wr_en = 1'b0; if1.rd_en = 1'b0; if1.flush = 1'b0; if1.din = '0;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    // Reset / idle state
    check("rst_empty",  32'(if0.empty), 1);
    check("rst_aempty", 32'(if0.almost_empty), 1);
    check("rst_full",   32'(if0.full), 0);
    check("rst_afull",  32'(if0.almost_full), 0);
    check("rst_count",  32'(if0.count), 0);
    check("rst_dout",   32'(if0.dout), 0);
    check("rst_ovf",    32'(if0.overflow), 0);
    check("rst_udf",    32'(if0.underflow), 0);
    check("rst_dout1",  32'(if1.dout), 0);

    // Fill with 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      if0.wr_en = 1'b1;
      if0.din   = 6'(i);
      cyc();
      check("fill_count", 32'(if0.count), 32'(i));
      check("fill_afull", 32'(if0.almost_full), (i >= 6) ? 1 : 0);
      check("fill_full",  32'(if0.full), (i == 8) ? 1 : 0);
    end
    // Extra write into a full FIFO is rejected
    if0.din = 6'h3F;
    cyc();
    if0.wr_en = 1'b0;
    check("ovf_set",   32'(if0.overflow), 1);
    check("ovf_count", 32'(if0.count), 8);

    // Drain: data in order, 0x3F never appears
    if0.rd_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      check("drain_dout", 32'(if0.dout), 32'(i));
    end
    if0.rd_en = 1'b0;
    check("drain_empty", 32'(if0.empty), 1);
    check("drain_udf",   32'(if0.underflow), 0);

    // Preload four words, then 20 cycles of simultaneous push/pop across wrap
    for (int i = 0; i < 4; i++) begin
      if0.wr_en = 1'b1;
      if0.din   = 6'(8'h10 + i);
      cyc();
    end
    check("pre_count", 32'(if0.count), 4);
    if0.rd_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if0.din = 6'(8'h14 + k);
      cyc();
      check("rw_dout",   32'(if0.dout), 32'(8'h10 + k));
      check("rw_count",  32'(if0.count), 4);
      check("rw_afull",  32'(if0.almost_full), 0);
      check("rw_aempty", 32'(if0.almost_empty), 0);
    end
    if0.wr_en = 1'b0;
    for (int k = 20; k < 24; k++) begin
      cyc();
      check("rw_tail", 32'(if0.dout), 32'(8'h10 + k));
    end
    if0.rd_en = 1'b0;
    check("rw_empty", 32'(if0.empty), 1);
    check("rw_udf",   32'(if0.underflow), 0);

    // Read+write on empty: write lands, read rejected
    if0.wr_en = 1'b1;
    if0.rd_en = 1'b1;
    if0.din   = 6'h2A;
    cyc();
    if0.wr_en = 1'b0;
    check("ew_udf",   32'(if0.underflow), 1);
    check("ew_count", 32'(if0.count), 1);
    cyc();
    if0.rd_en = 1'b0;
    check("ew_dout",  32'(if0.dout), 32'h2A);
    check("ew_empty", 32'(if0.empty), 1);

    // FWFT instance: word shows without rd_en, pop empties it
    check("fw_idle", 32'(if1.dout), 0);
    if1.wr_en = 1'b1;
    if1.din   = 6'h15;
    cyc();
    if1.wr_en = 1'b0;
    check("fw_dout",  32'(if1.dout), 32'h15);
    check("fw_empty", 32'(if1.empty), 0);
    cyc();
    check("fw_hold", 32'(if1.dout), 32'h15);
    if1.rd_en = 1'b1;
    cyc();
    if1.rd_en = 1'b0;
    check("fw_pop_empty", 32'(if1.empty), 1);
    check("fw_pop_dout",  32'(if1.dout), 0);

    // Fill to 5, then flush together with wr/rd
    for (int i = 0; i < 5; i++) begin
      if0.wr_en = 1'b1;
      if0.din   = 6'(8'h31 + i);
      cyc();
    end
    check("fl_pre_count", 32'(if0.count), 5);
    if0.rd_en = 1'b1;
    if0.flush = 1'b1;
    if0.din   = 6'h3E;
    cyc();
    if0.flush = 1'b0;
    if0.wr_en = 1'b0;
    if0.rd_en = 1'b0;
    check("fl_count", 32'(if0.count), 0);
    check("fl_empty", 32'(if0.empty), 1);
    check("fl_udf",   32'(if0.underflow), 0);
    check("fl_ovf",   32'(if0.overflow), 0);
    check("fl_dout",  32'(if0.dout), 0);

    // Rebuild some state, then assert reset between clock edges
    if0.wr_en = 1'b1;
    if0.din   = 6'h0A;
    cyc();
    if0.din   = 6'h0B;
    cyc();
    if0.wr_en = 1'b0;
    if0.rd_en = 1'b1;
    cyc();
    if0.rd_en = 1'b0;
    check("pr_dout",  32'(if0.dout), 32'h0A);
    check("pr_count", 32'(if0.count), 1);
    if0.wr_en = 1'b1;
    if0.din   = 6'h0C;
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_count",  32'(if0.count), 0);
    check("ar_dout",   32'(if0.dout), 0);
    check("ar_empty",  32'(if0.empty), 1);
    check("ar_aempty", 32'(if0.almost_empty), 1);
    check("ar_full",   32'(if0.full), 0);
    @(negedge clk);
    if0.wr_en = 1'b0;
    cyc();
    check("ar_hold_count", 32'(if0.count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    if0.wr_en = 1'b1;
    if0.din   = 6'h0C;
    cyc();
    if0.wr_en = 1'b0;
    check("post_count", 32'(if0.count), 1);
    if0.rd_en = 1'b1;
    cyc();
    if0.rd_en = 1'b0;
    check("post_dout",  32'(if0.dout), 32'h0C);
    check("post_empty", 32'(if0.empty), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
